// File: rtl/pci_initiator.sv
// rtl/pci_initiator.sv - PCI bus-master burst engine with a 4-word host buffer
// Optional DEVSEL master-abort timeout: define PCI_INIT_TIMEOUT_EN.
module pci_initiator (
  input  logic        clk,
  input  logic        rst,
  input  logic        buf_we,
  input  logic [1:0]  buf_idx,
  input  logic [31:0] buf_wdata,
  output logic [31:0] buf_rdata,
  input  logic        start,
  input  logic        cmd_write,
  input  logic [31:0] addr,
  input  logic [2:0]  len,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic [2:0]  beats,
  output logic        Frame,
  output logic        IRDY,
  output logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  input  logic        DEVSEL,
  input  logic        TRDY
);

  localparam int         MAX_BURST = 4;
  localparam logic [3:0] PCI_READ  = 4'b0010;
  localparam logic [3:0] PCI_WRITE = 4'b0011;

`ifdef PCI_INIT_TIMEOUT_EN
  localparam int DEVSEL_TIMEOUT = 5;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, ABORT} state_t;
  logic [2:0] to_cnt;
  logic       abort_q;
  assign abort = abort_q;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  assign abort = 1'b0;
`endif

  state_t      state;
  logic        cmd_wr;
  logic [2:0]  len_q;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic [31:0] buf_mem [MAX_BURST];

  logic len_ok, phase_done, last_phase;

  assign len_ok     = (len != 3'd0) && (len <= 3'd4);
  assign phase_done = (state == DATA) && !IRDY && !TRDY && !DEVSEL;
  assign last_phase = (beats + 3'd1) == len_q;
  assign buf_rdata  = buf_mem[buf_idx];
  assign AD         = ad_oe ? ad_out : 32'bz;

  // Buffer has no reset; the FSM owns it while busy so read data lands here.
  always_ff @(posedge clk) begin
    if (phase_done && !cmd_wr)
      buf_mem[beats[1:0]] <= AD;
    else if (buf_we && !busy)
      buf_mem[buf_idx] <= buf_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      Frame  <= 1'b1;
      IRDY   <= 1'b1;
      CBE    <= 4'b0000;
      ad_out <= 32'd0;
      ad_oe  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      beats  <= 3'd0;
      cmd_wr <= 1'b0;
      len_q  <= 3'd0;
`ifdef PCI_INIT_TIMEOUT_EN
      to_cnt  <= 3'd0;
      abort_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && len_ok) begin
            state  <= ADDR;
            Frame  <= 1'b0;
            CBE    <= cmd_write ? PCI_WRITE : PCI_READ;
            ad_out <= addr;
            ad_oe  <= 1'b1;
            busy   <= 1'b1;
            beats  <= 3'd0;
            cmd_wr <= cmd_write;
            len_q  <= len;
`ifdef PCI_INIT_TIMEOUT_EN
            to_cnt  <= 3'd0;
            abort_q <= 1'b0;
`endif
          end
        end
        ADDR: begin
          state  <= DATA;
          IRDY   <= 1'b0;
          ad_out <= buf_mem[0];
          ad_oe  <= cmd_wr;
          if (len_q == 3'd1)
            Frame <= 1'b1;
        end
        DATA: begin
          if (phase_done) begin
            beats <= beats + 3'd1;
            if (last_phase) begin
              state <= IDLE;
              IRDY  <= 1'b1;
              ad_oe <= 1'b0;
              CBE   <= 4'b0000;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              ad_out <= buf_mem[beats[1:0] + 2'd1];
              // Frame rises as the final phase begins.
              if ((beats + 3'd2) == len_q)
                Frame <= 1'b1;
            end
          end
`ifdef PCI_INIT_TIMEOUT_EN
          else if (DEVSEL) begin
            if (to_cnt == 3'(DEVSEL_TIMEOUT - 1)) begin
              state <= ABORT;
              Frame <= 1'b1;
              ad_oe <= 1'b0;
            end else begin
              to_cnt <= to_cnt + 3'd1;
            end
          end else begin
            to_cnt <= 3'd0;
          end
        end
        ABORT: begin
          state   <= IDLE;
          IRDY    <= 1'b1;
          CBE     <= 4'b0000;
          busy    <= 1'b0;
          done    <= 1'b1;
          abort_q <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
